// File: rtl/vga_timing_gen.sv
// Raster timing for 640x480@60: clock divider, x/y counters, syncs and per-frame strobes.
// All outputs are registered together, so x, y, syncs and active_pixels reach renderers with zero skew.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active_pixels,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0] h_nxt, v_nxt;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       pix_tick_q, pix_tick_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;
  logic       vblank_start_q, vblank_start_d;

  always_comb begin
    div_cnt_d      = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
    pix_tick_d     = (div_cnt_d == DIV_LAST);

    h_nxt          = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
    v_nxt          = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_nxt        = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end

    h_cnt_d        = h_cnt_q;
    v_cnt_d        = v_cnt_q;
    x_d            = x_q;
    y_d            = y_q;
    active_d       = active_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    frame_start_d  = 1'b0;
    vblank_start_d = 1'b0;

    // Every presented signal is derived from the same next position, keeping them aligned.
    if (pix_tick_q) begin
      h_cnt_d        = h_nxt;
      v_cnt_d        = v_nxt;
      x_d            = h_nxt;
      y_d            = v_nxt;
      active_d       = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hsync_d        = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
      vsync_d        = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
      frame_start_d  = (h_nxt == 10'd0) && (v_nxt == 10'd0);
      vblank_start_d = (h_nxt == 10'd0) && (v_nxt == V_VIS);
    end
  end

  // Internal counters park on the last position so the first tick lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q      <= 4'd0;
      pix_tick_q     <= 1'b0;
      h_cnt_q        <= H_LAST;
      v_cnt_q        <= V_LAST;
      x_q            <= 10'd0;
      y_q            <= 10'd0;
      active_q       <= 1'b0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pix_tick_q     <= pix_tick_d;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      x_q            <= x_d;
      y_q            <= y_d;
      active_q       <= active_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign pix_tick      = pix_tick_q;
  assign x             = x_q;
  assign y             = y_q;
  assign active_pixels = active_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign frame_start   = frame_start_q;
  assign vblank_start  = vblank_start_q;

endmodule
